// File: rtl/dmem_arb_pkg.sv
// Shared types and default widths for the data-memory arbiter.
package dmem_arb_pkg;

  localparam int unsigned DefAddrW = 8;
  localparam int unsigned DefDataW = 32;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StAccess = 2'd1,
    StResp   = 2'd2
  } state_e;

  // Port identifiers double as the bit index into the request vector.
  typedef enum logic {
    PortCpu = 1'b0,
    PortDbg = 1'b1
  } port_e;

endpackage

// File: rtl/arb_rr2.sv
// Two-way round-robin picker: on a tie, grants the port that did not win last time.
module arb_rr2
  import dmem_arb_pkg::*;
(
  input  logic [1:0] req_i,    // bit 0 = CPU, bit 1 = DBG
  input  logic       last_i,   // port granted most recently
  output logic       grant_o,
  output logic       valid_o
);

  // Pick a single requester; ties alternate against the last grant.
  always_comb begin
    valid_o = |req_i;
    grant_o = PortCpu;
    case (req_i)
      2'b01:   grant_o = PortCpu;
      2'b10:   grant_o = PortDbg;
      2'b11:   grant_o = ~last_i;
      default: grant_o = PortCpu;
    endcase
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Arbitrates a CPU port and a debug/loader port onto a single-ported data memory.
// One access is in flight at a time: IDLE -> ACCESS (one memory cycle) -> RESP (ready pulse).
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = DefAddrW,
  parameter int unsigned DATA_W = DefDataW
) (
  input  logic              clk_i,
  input  logic              rst_ni,

  input  logic              cpu_req_i,
  input  logic              cpu_we_i,
  input  logic [ADDR_W-1:0] cpu_adr_i,
  input  logic [DATA_W-1:0] cpu_wd_i,
  output logic              cpu_ready_o,
  output logic [DATA_W-1:0] cpu_rd_o,
  output logic              cpu_err_o,

  input  logic              dbg_req_i,
  input  logic              dbg_we_i,
  input  logic [ADDR_W-1:0] dbg_adr_i,
  input  logic [DATA_W-1:0] dbg_wd_i,
  output logic              dbg_ready_o,
  output logic [DATA_W-1:0] dbg_rd_o,
  output logic              dbg_err_o,

  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_adr_o,
  output logic [DATA_W-1:0] mem_wd_o,
  input  logic [DATA_W-1:0] mem_rd_i
);

  state_e              state_q;
  port_e               grant_q;
  port_e               last_q;
  logic                acc_we_q;
  logic [ADDR_W-1:0]   acc_adr_q;
  logic [DATA_W-1:0]   acc_wd_q;
  logic                cpu_ready_q, dbg_ready_q;
  logic                cpu_err_q, dbg_err_q;
  logic [DATA_W-1:0]   cpu_rd_q, dbg_rd_q;

  logic [1:0]          arb_req;
  logic                pick;
  logic                pick_valid;
  logic                aligned;

  assign aligned = (acc_adr_q[1:0] == 2'b00);

  // In RESP the completing port's request is ignored so the other port gets the next slot.
  always_comb begin
    arb_req = {dbg_req_i, cpu_req_i};
    if (state_q == StResp) begin
      if (grant_q == PortDbg) arb_req[1] = 1'b0;
      else                    arb_req[0] = 1'b0;
    end
  end

  arb_rr2 u_arb (
    .req_i   (arb_req),
    .last_i  (last_q),
    .grant_o (pick),
    .valid_o (pick_valid)
  );

  // Arbitration FSM: latches the granted request, captures read data and raises ready.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      grant_q     <= PortCpu;
      last_q      <= PortDbg;
      acc_we_q    <= 1'b0;
      acc_adr_q   <= '0;
      acc_wd_q    <= '0;
      cpu_ready_q <= 1'b0;
      dbg_ready_q <= 1'b0;
      cpu_err_q   <= 1'b0;
      dbg_err_q   <= 1'b0;
      cpu_rd_q    <= '0;
      dbg_rd_q    <= '0;
    end else begin
      cpu_ready_q <= 1'b0;
      dbg_ready_q <= 1'b0;
      unique case (state_q)
        StIdle, StResp: begin
          if (pick_valid) begin
            state_q <= StAccess;
            grant_q <= port_e'(pick);
            last_q  <= port_e'(pick);
            if (pick == PortDbg) begin
              acc_we_q  <= dbg_we_i;
              acc_adr_q <= dbg_adr_i;
              acc_wd_q  <= dbg_wd_i;
            end else begin
              acc_we_q  <= cpu_we_i;
              acc_adr_q <= cpu_adr_i;
              acc_wd_q  <= cpu_wd_i;
            end
          end else begin
            state_q <= StIdle;
          end
        end
        StAccess: begin
          state_q <= StResp;
          // Misaligned accesses report an error and return zero data.
          if (grant_q == PortDbg) begin
            dbg_ready_q <= 1'b1;
            dbg_err_q   <= ~aligned;
            dbg_rd_q    <= aligned ? mem_rd_i : '0;
          end else begin
            cpu_ready_q <= 1'b1;
            cpu_err_q   <= ~aligned;
            cpu_rd_q    <= aligned ? mem_rd_i : '0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Memory bus is only driven during ACCESS; reset forces IDLE and so drops mem_we at once.
  always_comb begin
    mem_we_o  = 1'b0;
    mem_adr_o = '0;
    mem_wd_o  = '0;
    if (state_q == StAccess) begin
      mem_we_o  = acc_we_q & aligned;
      mem_adr_o = acc_adr_q;
      mem_wd_o  = acc_wd_q;
    end
  end

  assign cpu_ready_o = cpu_ready_q;
  assign cpu_rd_o    = cpu_rd_q;
  assign cpu_err_o   = cpu_err_q;
  assign dbg_ready_o = dbg_ready_q;
  assign dbg_rd_o    = dbg_rd_q;
  assign dbg_err_o   = dbg_err_q;

endmodule
